// File: rtl/fifo_drain_framer.sv
// Pops a show-ahead FIFO into fixed-length packets on a valid/ready stream, 1-cycle latency, 2-entry output buffer.
// fifo_r_en never depends on out_ready; define FRAMER_CSUM_EN to append a modular-sum checksum word per packet.
module fifo_drain_framer #(
    parameter int DATA_WIDTH = 32,
    parameter int PKT_LEN    = 8,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_r_data,
    input  logic                  fifo_empty,
    output logic                  fifo_r_en,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      pkt_count,
    output logic                  busy
);

    localparam int WC_W = $clog2(PKT_LEN + 1);

`ifdef FRAMER_CSUM_EN
    typedef enum logic [1:0] {IDLE, PAYLOAD, CSUM} state_t;
`else
    typedef enum logic {IDLE, PAYLOAD} state_t;
`endif

    state_t                state;
    logic [1:0]            occ;
    logic [WC_W-1:0]       wcnt;
    logic                  flush_pend;
    logic [DATA_WIDTH-1:0] head_dat;
    logic [DATA_WIDTH-1:0] tail_dat;
    logic                  head_last;
    logic                  tail_last;

    logic                  accept;
    logic                  eff_flush;
    logic                  pkt_end;
    logic                  push;
    logic                  push_last;
    logic [DATA_WIDTH-1:0] push_dat;

    assign fifo_r_en = !rst && (state == IDLE || state == PAYLOAD) && !fifo_empty && (occ <= 2'd1);
    assign accept    = (occ != 2'd0) && out_ready;
    assign eff_flush = (state == PAYLOAD) && (flush || flush_pend);
    assign pkt_end   = fifo_r_en && ((wcnt == WC_W'(PKT_LEN - 1)) || eff_flush);

`ifdef FRAMER_CSUM_EN
    logic [DATA_WIDTH-1:0] csum;
    logic                  csum_push;

    assign csum_push = (state == CSUM) && (occ <= 2'd1);
    assign push      = fifo_r_en || csum_push;
    assign push_dat  = csum_push ? csum : fifo_r_data;
    assign push_last = csum_push;
`else
    assign push      = fifo_r_en;
    assign push_dat  = fifo_r_data;
    assign push_last = pkt_end;
`endif

    assign out_data  = head_dat;
    assign out_valid = (occ != 2'd0);
    assign out_last  = out_valid && head_last;
    assign busy      = (state != IDLE) || (occ != 2'd0);

    // Push needs occ<=1 and accept needs occ>=1, so push+accept only happens at occ==1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ       <= 2'd0;
            head_dat  <= '0;
            head_last <= 1'b0;
            tail_dat  <= '0;
            tail_last <= 1'b0;
        end else begin
            case ({push, accept})
                2'b10: begin
                    if (occ == 2'd0) begin
                        head_dat  <= push_dat;
                        head_last <= push_last;
                    end else begin
                        tail_dat  <= push_dat;
                        tail_last <= push_last;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head_dat  <= tail_dat;
                    head_last <= tail_last;
                    occ       <= occ - 2'd1;
                end
                2'b11: begin
                    head_dat  <= push_dat;
                    head_last <= push_last;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_count <= '0;
        end else if (accept && head_last) begin
            pkt_count <= pkt_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wcnt       <= '0;
            flush_pend <= 1'b0;
`ifdef FRAMER_CSUM_EN
            csum       <= '0;
`endif
        end else if (fifo_r_en) begin
            wcnt <= wcnt + WC_W'(1);
`ifdef FRAMER_CSUM_EN
            csum <= csum + fifo_r_data;
`endif
            if (pkt_end) begin
                flush_pend <= 1'b0;
`ifdef FRAMER_CSUM_EN
                state      <= CSUM;
`else
                state      <= IDLE;
                wcnt       <= '0;
`endif
            end else begin
                state <= PAYLOAD;
            end
`ifdef FRAMER_CSUM_EN
        // Flush with nothing to pop closes the packet on the words already summed.
        end else if (eff_flush) begin
            state      <= CSUM;
            flush_pend <= 1'b0;
        end else if (csum_push) begin
            state <= IDLE;
            wcnt  <= '0;
            csum  <= '0;
        end
`else
        end else if (state == PAYLOAD && flush) begin
            flush_pend <= 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_fifo_drain_framer.sv
// Self-checking bench for fifo_drain_framer: queue-based FIFO model upstream, packetizing scoreboard downstream.
// Expectations follow FRAMER_CSUM_EN as the design does.
module tb_fifo_drain_framer;

    localparam int DW      = 32;
    localparam int PKT_LEN = 8;
    localparam int CW      = 16;

`ifdef FRAMER_CSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] fifo_r_data;
    logic          fifo_empty;
    logic          fifo_r_en;
    logic          flush;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;
    logic [CW-1:0] pkt_count;
    logic          busy;

    fifo_drain_framer #(.DATA_WIDTH(DW), .PKT_LEN(PKT_LEN), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .fifo_r_data(fifo_r_data), .fifo_empty(fifo_empty),
        .fifo_r_en(fifo_r_en), .flush(flush), .out_data(out_data), .out_valid(out_valid),
        .out_last(out_last), .out_ready(out_ready), .pkt_count(pkt_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW:0]   exp_q[$];
    int            m_cnt = 0;
    logic [DW-1:0] m_sum = '0;
    bit            m_pend = 1'b0;
    int            m_pkts = 0;

    int            pops = 0;
    int            run = 0;
    int            max_run = 0;
    logic [DW-1:0] last_acc = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty  = (fifo_q.size() == 0);
        fifo_r_data = fifo_empty ? '0 : fifo_q[0];
    endtask

    task automatic m_close();
        if (CSUM_ON) exp_q.push_back({m_sum, 1'b1});
        m_pkts++;
        m_cnt  = 0;
        m_sum  = '0;
        m_pend = 1'b0;
    endtask

    // Reference packetizer: each word enters the FIFO and the expected stream at once.
    task automatic push_word(input logic [DW-1:0] w);
        bit close;
        fifo_q.push_back(w);
        m_cnt++;
        m_sum = m_sum + w;
        close = (m_cnt == PKT_LEN) || m_pend;
        exp_q.push_back({w, close && !CSUM_ON});
        if (close) m_close();
        drive_fifo();
    endtask

    task automatic m_flush();
        if (m_cnt > 0) begin
            if (CSUM_ON) m_close();
            else m_pend = 1'b1;
        end
    endtask

    task automatic tick();
        logic ren, acc, l;
        logic [DW-1:0] d;
        logic [DW:0] e;
        #1;
        ren = fifo_r_en;
        acc = out_valid && out_ready;
        d   = out_data;
        l   = out_last;
        if (ren) begin
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        if (acc) begin
            check("sb_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_data", d, e[DW:1]);
                check("sb_last", l, e[0]);
            end
            if (l) last_acc = d;
        end
        @(posedge clk);
        #1;
        if (ren) begin
            pops++;
            check("pop_nonempty", fifo_q.size() > 0, 1);
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        end
        flush = 1'b0;
        drive_fifo();
        @(negedge clk);
    endtask

    task automatic drain(input bit toggle, input int maxc);
        int n = 0;
        while ((fifo_q.size() > 0 || exp_q.size() > 0) && n < maxc) begin
            out_ready = toggle ? n[0] : 1'b1;
            tick();
            n++;
        end
        out_ready = 1'b1;
        check("drain_done", fifo_q.size() + exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b1;
        drive_fifo();
        @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_fifo_r_en", fifo_r_en, 0);
        check("rst_busy", busy, 0);
        check("rst_pkt_count", pkt_count, 0);
        @(negedge clk);
        rst = 1'b0;

        // Full packet of 1..8.
        max_run = 0;
        for (int i = 1; i <= 8; i++) push_word(DW'(i));
        drain(1'b0, 100);
        check("a_ren_run", max_run, 8);
        check("a_pkt_count", pkt_count, 1);
        check("a_last_word", last_acc, CSUM_ON ? 32'h24 : 32'h8);

        // Checksum wrap with all-ones words.
        for (int i = 0; i < 16; i++) push_word('1);
        drain(1'b0, 100);
        check("b_pkt_count", pkt_count, 3);
        check("b_last_word", last_acc, CSUM_ON ? 32'hFFFF_FFF8 : 32'hFFFF_FFFF);

        // Back-pressure: two pops then hold.
        out_ready = 1'b0;
        p0 = pops;
        for (int i = 0; i < 8; i++) push_word(32'h100 + DW'(i));
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_data", out_data, 32'h100);
            check("bp_hold_valid", out_valid, 1);
        end
        #1;
        check("bp_pops", pops - p0, 2);
        check("bp_ren_low", fifo_r_en, 0);
        @(negedge clk);
        drain(1'b0, 100);
        check("bp_pkt_count", pkt_count, CW'(m_pkts));

        // Flush after three words with the FIFO empty.
        push_word(32'hA);
        push_word(32'hB);
        push_word(32'hC);
        drain(1'b0, 50);
        flush = 1'b1;
        m_flush();
        tick();
        drain(1'b0, 50);
        for (int i = 0; i < 3; i++) tick();
        check("fl_last_word", last_acc, CSUM_ON ? 32'h21 : 32'h107);
        check("fl_busy_open", busy, !CSUM_ON);
        push_word(32'hD);
        drain(1'b0, 50);
        flush = 1'b1;
        m_flush();
        tick();
        drain(1'b0, 50);
        check("fl_d_last", last_acc, 32'hD);
        check("fl_pkt_count", pkt_count, CW'(m_pkts));

        // Flush in IDLE is ignored: next packet is full length.
        check("idle_busy", busy, 0);
        flush = 1'b1;
        m_flush();
        tick();
        check("idle_flush_busy", busy, 0);
        for (int i = 0; i < 8; i++) push_word(32'h200 + DW'(i));
        drain(1'b0, 100);
        check("idle_pkt_count", pkt_count, CW'(m_pkts));

        // Reset mid-packet: 5 words popped, buffer full.
        for (int i = 0; i < 3; i++) push_word(32'h300 + DW'(i));
        drain(1'b0, 50);
        out_ready = 1'b0;
        for (int i = 3; i < 7; i++) push_word(32'h300 + DW'(i));
        for (int i = 0; i < 4; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_last", out_last, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_ren", fifo_r_en, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_pkt_count", pkt_count, 0);
        fifo_q.delete();
        exp_q.delete();
        m_cnt = 0;
        m_sum = '0;
        m_pend = 1'b0;
        m_pkts = 0;
        drive_fifo();
        @(negedge clk);
        rst = 1'b0;

        // 64 random words, out_ready toggling every cycle.
        for (int i = 0; i < 64; i++) push_word($urandom());
        drain(1'b1, 600);
        check("rnd_pkt_count_model", pkt_count, CW'(m_pkts));
        check("rnd_pkt_count", pkt_count, 8);
        check("rnd_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
